// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM test sequencer and the SRAM R/W tester it drives.
package sram_test_pkg;

  localparam int unsigned pCYCLES_PER_ADDR = 12;
  localparam int unsigned pGAP_CYCLES      = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } seq_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_window_timer.sv
// Loadable down-counter; holds at zero and flags it. Load takes priority over decrement.
module sram_window_timer #(
  parameter int unsigned Width = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sram_test_sequencer.sv
// Runs repeated fixed-length SRAM tester windows with active dropped between them and
// accumulates per-iteration verdicts into saturating host-readable counters.
module sram_test_sequencer import sram_test_pkg::*; #(
  parameter int unsigned pADDR_WIDTH      = 20,
  parameter int unsigned pCYCLES_PER_ADDR = sram_test_pkg::pCYCLES_PER_ADDR,
  parameter int unsigned pRUN_MARGIN      = 16,
  parameter int unsigned pGAP_CYCLES      = sram_test_pkg::pGAP_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        I_start,
  input  logic        I_stop,
  input  logic [15:0] I_iterations,
  input  logic [7:0]  I_top_address,
  input  logic        I_pass,
  input  logic        I_fail,
  output logic        O_active,
  output logic [7:0]  O_top_address,
  output logic        O_busy,
  output logic        O_done,
  output logic [15:0] O_iter_count,
  output logic [15:0] O_fail_count,
  output logic [15:0] O_first_fail_iter,
  output logic        O_no_response
);

  localparam int unsigned CntW = pADDR_WIDTH + 5;

  // Last count of a run window: (top+1)*cycles + margin - 1, top 0 meaning the full array.
  function automatic logic [CntW-1:0] window_last(input logic [7:0] top);
    logic [63:0] top_eff;
    top_eff = (top == 8'd0) ? ((64'd1 << pADDR_WIDTH) - 64'd1) : {56'd0, top};
    return CntW'((top_eff + 64'd1) * 64'(pCYCLES_PER_ADDR) + 64'(pRUN_MARGIN) - 64'd1);
  endfunction

  seq_state_e  state_d, state_q;
  logic [15:0] iters_d, iters_q;
  logic [7:0]  top_d, top_q;
  logic [15:0] iter_count_d, iter_count_q;
  logic [15:0] fail_count_d, fail_count_q;
  logic [15:0] first_fail_d, first_fail_q;
  logic        no_resp_d, no_resp_q;
  logic        seen_pass_d, seen_pass_q;
  logic        seen_fail_d, seen_fail_q;
  logic        active_d, active_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;

  logic            timer_load, timer_en, timer_zero;
  logic [CntW-1:0] timer_val;
  logic            pass_now, fail_now;
  logic [15:0]     iter_new;

  sram_window_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       (timer_en),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d      = state_q;
    iters_d      = iters_q;
    top_d        = top_q;
    iter_count_d = iter_count_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    no_resp_d    = no_resp_q;
    seen_pass_d  = seen_pass_q;
    seen_fail_d  = seen_fail_q;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    timer_val    = window_last(top_q);
    pass_now     = seen_pass_q | I_pass;
    fail_now     = seen_fail_q | I_fail;
    iter_new     = sat_inc16(iter_count_q);

    unique case (state_q)
      StIdle, StDone: begin
        if (I_stop) begin
          state_d = StIdle;
        end else if (I_start) begin
          iters_d      = I_iterations;
          top_d        = I_top_address;
          iter_count_d = 16'd0;
          fail_count_d = 16'd0;
          first_fail_d = 16'hFFFF;
          no_resp_d    = 1'b0;
          seen_pass_d  = 1'b0;
          seen_fail_d  = 1'b0;
          timer_load   = 1'b1;
          timer_val    = window_last(I_top_address);
          state_d      = StRun;
        end
      end
      StRun: begin
        if (I_stop) begin
          seen_pass_d = 1'b0;
          seen_fail_d = 1'b0;
          state_d     = StIdle;
        end else if (timer_zero) begin
          // Last window cycle: this cycle's flags still count toward the verdict.
          iter_count_d = iter_new;
          if (fail_now) begin
            fail_count_d = sat_inc16(fail_count_q);
            if (first_fail_q == 16'hFFFF) first_fail_d = iter_count_q;
          end
          if (!pass_now && !fail_now) no_resp_d = 1'b1;
          seen_pass_d = 1'b0;
          seen_fail_d = 1'b0;
          if ((iters_q != 16'd0) && (iter_new == iters_q)) begin
            state_d = StDone;
          end else begin
            timer_load = 1'b1;
            timer_val  = CntW'(pGAP_CYCLES - 1);
            state_d    = StGap;
          end
        end else begin
          seen_pass_d = pass_now;
          seen_fail_d = fail_now;
          timer_en    = 1'b1;
        end
      end
      StGap: begin
        if (I_stop) begin
          state_d = StIdle;
        end else if (timer_zero) begin
          timer_load = 1'b1;
          state_d    = StRun;
        end else begin
          timer_en = 1'b1;
        end
      end
    endcase

    active_d = (state_d == StRun);
    busy_d   = (state_d == StRun) || (state_d == StGap);
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      iters_q      <= 16'd0;
      top_q        <= 8'd0;
      iter_count_q <= 16'd0;
      fail_count_q <= 16'd0;
      first_fail_q <= 16'hFFFF;
      no_resp_q    <= 1'b0;
      seen_pass_q  <= 1'b0;
      seen_fail_q  <= 1'b0;
      active_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      iters_q      <= iters_d;
      top_q        <= top_d;
      iter_count_q <= iter_count_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      no_resp_q    <= no_resp_d;
      seen_pass_q  <= seen_pass_d;
      seen_fail_q  <= seen_fail_d;
      active_q     <= active_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign O_active          = active_q;
  assign O_top_address     = top_q;
  assign O_busy            = busy_q;
  assign O_done            = done_q;
  assign O_iter_count      = iter_count_q;
  assign O_fail_count      = fail_count_q;
  assign O_first_fail_iter = first_fail_q;
  assign O_no_response     = no_resp_q;

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Randomized self-checking bench: tester flags are driven directly and a window-level model
// predicts the active waveform and the verdict counters.
module tb_sram_test_sequencer;

  localparam int CYC    = 12;
  localparam int MARGIN = 16;
  localparam int GAP    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        I_start = 1'b0;
  logic        I_stop = 1'b0;
  logic [15:0] I_iterations = 16'd0;
  logic [7:0]  I_top_address = 8'd0;
  logic        I_pass = 1'b0;
  logic        I_fail = 1'b0;
  logic        O_active, O_busy, O_done, O_no_response;
  logic [7:0]  O_top_address;
  logic [15:0] O_iter_count, O_fail_count, O_first_fail_iter;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] m_iter, m_fail, m_first, m_iters;
  logic        m_nr, m_busy;
  logic [7:0]  m_top;

  always #5 clk = ~clk;

  sram_test_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .I_start           (I_start),
    .I_stop            (I_stop),
    .I_iterations      (I_iterations),
    .I_top_address     (I_top_address),
    .I_pass            (I_pass),
    .I_fail            (I_fail),
    .O_active          (O_active),
    .O_top_address     (O_top_address),
    .O_busy            (O_busy),
    .O_done            (O_done),
    .O_iter_count      (O_iter_count),
    .O_fail_count      (O_fail_count),
    .O_first_fail_iter (O_first_fail_iter),
    .O_no_response     (O_no_response)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string tag);
    vectors++;
    if ({O_active, O_busy, O_done, O_no_response} !== 4'b0000 || O_top_address !== 8'd0 ||
        O_iter_count !== 16'd0 || O_fail_count !== 16'd0 || O_first_fail_iter !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL %s: got act=%b busy=%b done=%b nr=%b top=%h it=%h fc=%h ff=%h, expected 0s ff=ffff",
               tag, O_active, O_busy, O_done, O_no_response, O_top_address, O_iter_count,
               O_fail_count, O_first_fail_iter);
    end
  endtask

  task automatic do_start(input logic [15:0] iters, input logic [7:0] top);
    I_iterations  = iters;
    I_top_address = top;
    I_start       = 1'b1;
    @(negedge clk);
    I_start       = 1'b0;
    I_iterations  = 16'($urandom);
    I_top_address = 8'($urandom);
    m_iter = 16'd0; m_fail = 16'd0; m_first = 16'hFFFF; m_nr = 1'b0;
    m_busy = 1'b1; m_top = top; m_iters = iters;
  endtask

  // Walks t cycles after start; mode 0 random verdicts, 1 all pass, 2 fail in iteration 1 only,
  // 3 no response. kind: 0 none, 1 pass, 2 fail, 3 pass+fail.
  task automatic run_windows(input int top, input int n_t, input int stop_t, input int mode,
                             input bit force_sat);
    int w, p, k, j, kind, pos;
    w = (top + 1) * CYC + MARGIN;
    p = w + GAP;
    kind = 1;
    pos = 0;
    for (int t = 0; t < n_t; t++) begin
      k = t / p;
      j = t % p;
      if (j == w) begin
        if (kind >= 2) begin
          if (m_first == 16'hFFFF) m_first = m_iter;
          if (m_fail != 16'hFFFF) m_fail = m_fail + 16'd1;
        end
        if (kind == 0) m_nr = 1'b1;
        if (m_iter != 16'hFFFF) m_iter = m_iter + 16'd1;
        if (m_iters != 16'd0 && m_iter == m_iters) m_busy = 1'b0;
        vectors++;
        if (O_iter_count !== m_iter || O_fail_count !== m_fail ||
            O_first_fail_iter !== m_first || O_no_response !== m_nr) begin
          miscompares++;
          $display("FAIL verdict iter %0d: got it=%h fc=%h ff=%h nr=%b, expected it=%h fc=%h ff=%h nr=%b",
                   k, O_iter_count, O_fail_count, O_first_fail_iter, O_no_response,
                   m_iter, m_fail, m_first, m_nr);
        end
      end
      if (j == 0) begin
        case (mode)
          1:       kind = 1;
          2:       kind = (k == 1) ? 2 : 1;
          3:       kind = 0;
          default: kind = $urandom_range(0, 3);
        endcase
        pos = ($urandom_range(0, 3) == 0) ? w - 1 : $urandom_range(0, w - 1);
      end
      vectors++;
      if (O_active !== (m_busy && j < w) || O_busy !== m_busy || O_done !== !m_busy ||
          O_top_address !== m_top) begin
        miscompares++;
        $display("FAIL window t=%0d: got act=%b busy=%b done=%b top=%h, expected act=%b busy=%b done=%b top=%h",
                 t, O_active, O_busy, O_done, O_top_address, (m_busy && j < w), m_busy, !m_busy, m_top);
      end
      if (j < w) begin
        I_pass = (kind == 1 || kind == 3) && (j == pos);
        I_fail = (kind >= 2) && (j >= pos);
      end else begin
        I_pass = 1'($urandom);
        I_fail = 1'($urandom);
      end
      if (mode == 0 && m_busy && $urandom_range(0, 19) == 0) begin
        I_start       = 1'b1;
        I_iterations  = 16'($urandom);
        I_top_address = 8'($urandom);
      end else begin
        I_start = 1'b0;
      end
      if (force_sat && t == 0) begin
        force dut.iter_count_q = 16'hFFFE;
        m_iter = 16'hFFFE;
      end
      if (force_sat && t == 1) release dut.iter_count_q;
      if (t == stop_t) begin
        I_stop = 1'b1; I_start = 1'b0; I_pass = 1'b0; I_fail = 1'b0;
        @(negedge clk);
        I_stop = 1'b0;
        m_busy = 1'b0;
        vectors++;
        if (O_active !== 1'b0 || O_busy !== 1'b0 || O_done !== 1'b0 || O_iter_count !== m_iter) begin
          miscompares++;
          $display("FAIL stop: got act=%b busy=%b done=%b it=%h, expected 0 0 0 it=%h",
                   O_active, O_busy, O_done, O_iter_count, m_iter);
        end
        return;
      end
      @(negedge clk);
    end
    I_pass = 1'b0; I_fail = 1'b0; I_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_basic();
    do_start(16'd2, 8'd3);
    run_windows(3, 2 * (64 + GAP), -1, 1, 1'b0);
  endtask

  task automatic test_fail_iter();
    do_start(16'd2, 8'd3);  // restart from DONE
    run_windows(3, 2 * (64 + GAP), -1, 2, 1'b0);
  endtask

  task automatic test_no_response();
    do_start(16'd1, 8'd3);
    run_windows(3, 64 + GAP, -1, 3, 1'b0);
  endtask

  task automatic test_stop();
    do_start(16'd0, 8'd3);
    run_windows(3, 100000, 5 * (64 + GAP) + 30, 0, 1'b0);
  endtask

  task automatic test_start_stop_idle();
    I_start = 1'b1; I_stop = 1'b1;
    I_iterations = 16'd7; I_top_address = 8'd9;
    @(negedge clk);
    I_start = 1'b0; I_stop = 1'b0;
    repeat (2) begin
      vectors++;
      if (O_active !== 1'b0 || O_busy !== 1'b0 || O_done !== 1'b0 ||
          O_iter_count !== m_iter || O_top_address !== m_top) begin
        miscompares++;
        $display("FAIL start_stop: got act=%b busy=%b done=%b it=%h top=%h, expected 0 0 0 it=%h top=%h",
                 O_active, O_busy, O_done, O_iter_count, O_top_address, m_iter, m_top);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int top, iters;
    repeat (3) begin
      top   = $urandom_range(1, 5);
      iters = $urandom_range(1, 3);
      do_start(16'(iters), 8'(top));
      run_windows(top, iters * ((top + 1) * CYC + MARGIN + GAP), -1, 0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    do_start(16'd2, 8'd2);
    run_windows(2, 10, -1, 1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_reset_run");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start(16'd3, 8'd3);
    run_windows(3, 64 + 2, -1, 1, 1'b0);  // now in the gap after iteration 0
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_reset_gap");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    do_start(16'd0, 8'd1);
    run_windows(1, 3 * (2 * CYC + MARGIN + GAP), -1, 0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_fail_iter();
    test_no_response();
    test_stop();
    test_start_stop_idle();
    test_random();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
